// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock chime/alarm control path.
package clock_pkg;

  typedef enum logic [1:0] {IDLE, CHIME_LO, CHIME_HI, ALARM} state_t;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_00 = 8'h00;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/chime_sequencer_if.sv
// Time-of-day / alarm inputs and beep-stage control outputs of the chime sequencer.
interface chime_sequencer_if;
  logic       tick_1hz;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       set_mode;
  logic       alarm_en;
  logic [7:0] alarm_hh;
  logic [7:0] alarm_mm;
  logic       alarm_stop;
  logic       beep_rst_n;
  logic       beep_step;
  logic       tone_hi;
  logic       chime_active;
  logic       alarm_active;

  modport master (
    output tick_1hz, hh, mm, ss, set_mode, alarm_en, alarm_hh, alarm_mm, alarm_stop,
    input  beep_rst_n, beep_step, tone_hi, chime_active, alarm_active
  );

  modport slave (
    input  tick_1hz, hh, mm, ss, set_mode, alarm_en, alarm_hh, alarm_mm, alarm_stop,
    output beep_rst_n, beep_step, tone_hi, chime_active, alarm_active
  );
endinterface

// File: rtl/chime_time_match.sv
// Combinational time compares; a field with a non-decimal digit never matches.
module chime_time_match
  import clock_pkg::*;
#(
  parameter logic [7:0] CHIME_START = 8'h56
) (
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  output logic       chime_lo_hit,
  output logic       chime_hi_hit,
  output logic       alarm_hit
);

  logic mm_ok;
  logic ss_ok;

  assign mm_ok = bcd_valid(mm);
  assign ss_ok = bcd_valid(ss);

  assign chime_lo_hit = mm_ok && ss_ok && (mm == BCD_59) && (ss == CHIME_START);
  assign chime_hi_hit = (mm == BCD_00) && (ss == BCD_00);
  assign alarm_hit    = alarm_en && bcd_valid(hh) && mm_ok && ss_ok &&
                        bcd_valid(alarm_hh) && bcd_valid(alarm_mm) &&
                        (hh == alarm_hh) && (mm == alarm_mm) && (ss == BCD_00);

endmodule

// File: rtl/chime_sequencer.sv
// Decides when the beep-pattern stage runs: hourly chime and timed alarm.
module chime_sequencer
  import clock_pkg::*;
#(
  parameter int unsigned ALARM_SECS  = 30,
  parameter int unsigned HI_SECS     = 1,
  parameter logic [7:0]  CHIME_START = 8'h56
) (
  input logic clk,
  input logic rst,
  chime_sequencer_if.slave bus
);

  localparam logic [7:0] ALARM_LIM = 8'(ALARM_SECS);
  localparam logic [7:0] HI_LIM    = 8'(HI_SECS);

  state_t     state, state_nxt;
  logic [7:0] sec_cnt, sec_nxt, sec_inc;
  logic [2:0] beat_cnt, beat_nxt;
  logic       alarm_pend, pend_nxt;
  logic       hi_reload, reload_nxt;
  logic       tick_q;
  logic       beep_rst_n, rstn_nxt;
  logic       beep_step, step_nxt;
  logic       tone_hi, tone_nxt;
  logic       chime_lo_hit, chime_hi_hit, alarm_hit;

  chime_time_match #(.CHIME_START(CHIME_START)) u_match (
    .hh          (bus.hh),
    .mm          (bus.mm),
    .ss          (bus.ss),
    .alarm_en    (bus.alarm_en),
    .alarm_hh    (bus.alarm_hh),
    .alarm_mm    (bus.alarm_mm),
    .chime_lo_hit(chime_lo_hit),
    .chime_hi_hit(chime_hi_hit),
    .alarm_hit   (alarm_hit)
  );

  assign sec_inc = sec_cnt + 8'd1;

  always_comb begin
    state_nxt  = state;
    sec_nxt    = sec_cnt;
    beat_nxt   = beat_cnt;
    pend_nxt   = alarm_pend;
    reload_nxt = 1'b0;
    step_nxt   = 1'b0;
    rstn_nxt   = beep_rst_n;
    tone_nxt   = tone_hi;
    if (bus.set_mode) begin
      state_nxt = IDLE;
      sec_nxt   = '0;
      beat_nxt  = '0;
      pend_nxt  = 1'b0;
      rstn_nxt  = 1'b0;
      tone_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          rstn_nxt = 1'b0;
          tone_nxt = 1'b0;
          if (tick_q) begin
            if (chime_hi_hit) begin
              // Top-of-hour entry holds the stage in reset one cycle before stepping.
              state_nxt  = CHIME_HI;
              sec_nxt    = '0;
              reload_nxt = 1'b1;
              tone_nxt   = 1'b1;
              pend_nxt   = alarm_hit;
            end else if (chime_lo_hit) begin
              state_nxt = CHIME_LO;
              beat_nxt  = 3'd1;
              step_nxt  = 1'b1;
              rstn_nxt  = 1'b1;
              pend_nxt  = alarm_hit;
            end else if (alarm_hit) begin
              state_nxt = ALARM;
              sec_nxt   = '0;
              step_nxt  = 1'b1;
              rstn_nxt  = 1'b1;
              tone_nxt  = 1'b1;
            end
          end
        end
        CHIME_LO: begin
          if (tick_q) begin
            pend_nxt = alarm_pend | alarm_hit;
            if (beat_cnt == 3'd4 || chime_hi_hit) begin
              state_nxt  = CHIME_HI;
              sec_nxt    = '0;
              reload_nxt = 1'b1;
              rstn_nxt   = 1'b0;
              tone_nxt   = 1'b1;
            end else begin
              beat_nxt = beat_cnt + 3'd1;
              step_nxt = 1'b1;
            end
          end
        end
        CHIME_HI: begin
          tone_nxt = 1'b1;
          if (hi_reload) begin
            rstn_nxt = 1'b1;
            step_nxt = 1'b1;
          end
          if (tick_q) begin
            pend_nxt = alarm_pend | alarm_hit;
            if (sec_inc == HI_LIM) begin
              sec_nxt = '0;
              if (alarm_pend) begin
                // Deferred alarm runs its full duration after the chime.
                state_nxt = ALARM;
                pend_nxt  = 1'b0;
                step_nxt  = 1'b1;
                rstn_nxt  = 1'b1;
              end else begin
                state_nxt = IDLE;
                rstn_nxt  = 1'b0;
                tone_nxt  = 1'b0;
              end
            end else begin
              sec_nxt = sec_inc;
            end
          end
        end
        ALARM: begin
          rstn_nxt = 1'b1;
          if (bus.alarm_stop || (tick_q && sec_inc == ALARM_LIM)) begin
            state_nxt = IDLE;
            sec_nxt   = '0;
            rstn_nxt  = 1'b0;
            tone_nxt  = 1'b0;
          end else if (tick_q) begin
            sec_nxt  = sec_inc;
            step_nxt = 1'b1;
            tone_nxt = ~tone_hi;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (bus.alarm_stop) pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      sec_cnt    <= '0;
      beat_cnt   <= '0;
      alarm_pend <= 1'b0;
      hi_reload  <= 1'b0;
      tick_q     <= 1'b0;
      beep_rst_n <= 1'b0;
      beep_step  <= 1'b0;
      tone_hi    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sec_cnt    <= sec_nxt;
      beat_cnt   <= beat_nxt;
      alarm_pend <= pend_nxt;
      hi_reload  <= reload_nxt;
      tick_q     <= bus.tick_1hz;
      beep_rst_n <= rstn_nxt;
      beep_step  <= step_nxt;
      tone_hi    <= tone_nxt;
    end
  end

  assign bus.beep_rst_n   = beep_rst_n;
  assign bus.beep_step    = beep_step;
  assign bus.tone_hi      = tone_hi;
  assign bus.chime_active = (state == CHIME_LO) || (state == CHIME_HI);
  assign bus.alarm_active = (state == ALARM);

endmodule

// File: tb/tb_chime_sequencer.sv
// Scoreboard bench for chime_sequencer: per-second expectations queued at drive, checked after the tick.
module tb_chime_sequencer;

  typedef struct packed {
    logic       sf;     // beep_step on first output cycle after tick_q
    logic [2:0] n;      // beep_step pulses in the 4-cycle window
    logic       rf;     // beep_rst_n on first output cycle
    logic       tone;   // final tone_hi
    logic       rstn;   // final beep_rst_n
    logic       chime;  // final chime_active
    logic       alarm;  // final alarm_active
  } obs_t;

  localparam obs_t E_IDLE = '{sf:1'b0, n:3'd0, rf:1'b0, tone:1'b0, rstn:1'b0, chime:1'b0, alarm:1'b0};
  localparam obs_t E_LO   = '{sf:1'b1, n:3'd1, rf:1'b1, tone:1'b0, rstn:1'b1, chime:1'b1, alarm:1'b0};
  localparam obs_t E_HI   = '{sf:1'b0, n:3'd1, rf:1'b0, tone:1'b1, rstn:1'b1, chime:1'b1, alarm:1'b0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  chime_sequencer_if bus();

  chime_sequencer #(.ALARM_SECS(30), .HI_SECS(1), .CHIME_START(8'h56)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic obs_t e_alarm(input logic tone);
    obs_t e;
    e = '{sf:1'b1, n:3'd1, rf:1'b1, tone:tone, rstn:1'b1, chime:1'b0, alarm:1'b1};
    return e;
  endfunction

  // One second: tick pulse, counters advance on the same edge, then observe 4 output cycles.
  task automatic tick_chk(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input obs_t e, input string name);
    obs_t o;
    obs_t x;
    exp_q.push_back(e);
    @(negedge clk); bus.tick_1hz = 1'b1;
    @(negedge clk); bus.tick_1hz = 1'b0; bus.hh = h; bus.mm = m; bus.ss = s;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        o.sf = bus.beep_step;
        o.rf = bus.beep_rst_n;
      end
      if (bus.beep_step === 1'b1) o.n = o.n + 3'd1;
      if (i == 3) begin
        o.tone  = bus.tone_hi;
        o.rstn  = bus.beep_rst_n;
        o.chime = bus.chime_active;
        o.alarm = bus.alarm_active;
      end
    end
    x = exp_q.pop_front();
    checks++;
    if (o !== x) begin
      failures++;
      $display("FAIL %s %02h:%02h:%02h got sf,n,rf,tone,rstn,chime,alarm=%b expected %b",
               name, h, m, s, o, x);
    end
  endtask

  task automatic test_reset();
    logic [4:0] o;
    rst = 1'b0;
    bus.tick_1hz = 1'b0; bus.hh = 8'h12; bus.mm = 8'h00; bus.ss = 8'h00;
    bus.set_mode = 1'b0; bus.alarm_en = 1'b0; bus.alarm_hh = 8'h00; bus.alarm_mm = 8'h00;
    bus.alarm_stop = 1'b0;
    repeat (3) @(negedge clk);
    o = {bus.beep_rst_n, bus.beep_step, bus.tone_hi, bus.chime_active, bus.alarm_active};
    checks++;
    if (o !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got %b expected 00000", o);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_chime();
    bus.alarm_en = 1'b0;
    for (int s = 8'h50; s <= 8'h55; s++) tick_chk(8'h12, 8'h59, 8'(s), E_IDLE, "pre_chime");
    for (int s = 8'h56; s <= 8'h59; s++) tick_chk(8'h12, 8'h59, 8'(s), E_LO, "chime_lo");
    tick_chk(8'h13, 8'h00, 8'h00, E_HI,   "chime_hi");
    tick_chk(8'h13, 8'h00, 8'h01, E_IDLE, "chime_end");
    tick_chk(8'h13, 8'h00, 8'h02, E_IDLE, "post_chime");
  endtask

  task automatic test_alarm();
    bus.alarm_en = 1'b1; bus.alarm_hh = 8'h07; bus.alarm_mm = 8'h30;
    tick_chk(8'h07, 8'h29, 8'h59, E_IDLE, "pre_alarm");
    for (int k = 0; k < 30; k++)
      tick_chk(8'h07, 8'h30, 8'((k / 10) * 16 + (k % 10)), e_alarm((k % 2) == 0), "alarm_beat");
    tick_chk(8'h07, 8'h30, 8'h30, E_IDLE, "alarm_end");
    tick_chk(8'h07, 8'h30, 8'h31, E_IDLE, "post_alarm");
  endtask

  task automatic test_alarm_chime();
    obs_t e;
    int   s;
    bus.alarm_en = 1'b1; bus.alarm_hh = 8'h08; bus.alarm_mm = 8'h00;
    tick_chk(8'h07, 8'h59, 8'h55, E_IDLE, "ac_pre");
    for (int t = 8'h56; t <= 8'h59; t++) tick_chk(8'h07, 8'h59, 8'(t), E_LO, "ac_lo");
    tick_chk(8'h08, 8'h00, 8'h00, E_HI, "ac_hi");
    for (int k = 0; k < 30; k++) begin
      s = k + 1;
      e = e_alarm((k % 2) == 0);
      tick_chk(8'h08, 8'h00, 8'((s / 10) * 16 + (s % 10)), e, "ac_alarm");
    end
    tick_chk(8'h08, 8'h00, 8'h31, E_IDLE, "ac_end");
  endtask

  task automatic test_alarm_stop();
    logic [2:0] o;
    bus.alarm_en = 1'b1; bus.alarm_hh = 8'h07; bus.alarm_mm = 8'h30;
    for (int k = 0; k < 6; k++)
      tick_chk(8'h07, 8'h30, 8'(k), e_alarm((k % 2) == 0), "stop_beat");
    @(negedge clk); bus.alarm_stop = 1'b1;
    @(negedge clk); bus.alarm_stop = 1'b0;
    o = {bus.alarm_active, bus.beep_rst_n, bus.beep_step};
    checks++;
    if (o !== 3'b000) begin
      failures++;
      $display("FAIL alarm_stop got active,rstn,step=%b expected 000", o);
    end
    tick_chk(8'h07, 8'h30, 8'h06, E_IDLE, "after_stop");
  endtask

  task automatic test_set_mode();
    logic [1:0] o;
    bus.alarm_en = 1'b0;
    tick_chk(8'h12, 8'h59, 8'h55, E_IDLE, "sm_pre");
    tick_chk(8'h12, 8'h59, 8'h56, E_LO, "sm_lo");
    tick_chk(8'h12, 8'h59, 8'h57, E_LO, "sm_lo");
    @(negedge clk); bus.set_mode = 1'b1;
    @(negedge clk);
    o = {bus.chime_active, bus.beep_rst_n};
    checks++;
    if (o !== 2'b00) begin
      failures++;
      $display("FAIL set_mode_abort got chime,rstn=%b expected 00", o);
    end
    tick_chk(8'h12, 8'h59, 8'h58, E_IDLE, "sm_held");
    tick_chk(8'h12, 8'h59, 8'h59, E_IDLE, "sm_held");
    tick_chk(8'h13, 8'h00, 8'h00, E_IDLE, "sm_no_hi");
    bus.set_mode = 1'b0;
    tick_chk(8'h13, 8'h00, 8'h01, E_IDLE, "sm_release");
  endtask

  task automatic test_invalid_bcd();
    bus.alarm_en = 1'b0;
    tick_chk(8'h12, 8'h59, 8'h5A, E_IDLE, "bad_ss_chime");
    bus.alarm_en = 1'b1; bus.alarm_hh = 8'h0A; bus.alarm_mm = 8'h30;
    tick_chk(8'h0A, 8'h30, 8'h00, E_IDLE, "bad_hh_alarm");
  endtask

  task automatic test_rst_alarm();
    logic [4:0] o;
    bus.alarm_en = 1'b1; bus.alarm_hh = 8'h07; bus.alarm_mm = 8'h30;
    tick_chk(8'h07, 8'h30, 8'h00, e_alarm(1'b1), "ra_beat");
    tick_chk(8'h07, 8'h30, 8'h01, e_alarm(1'b0), "ra_beat");
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    o = {bus.beep_rst_n, bus.beep_step, bus.tone_hi, bus.chime_active, bus.alarm_active};
    checks++;
    if (o !== 5'b0) begin
      failures++;
      $display("FAIL rst_mid_alarm got %b expected 00000", o);
    end
    tick_chk(8'h07, 8'h30, 8'h02, E_IDLE, "ra_no_replay");
  endtask

  initial begin
    test_reset();
    test_chime();
    test_alarm();
    test_alarm_chime();
    test_alarm_stop();
    test_set_mode();
    test_invalid_bcd();
    test_rst_alarm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chime_sequencer.md
Name: chime_sequencer

Overview:
- Upstream controller for the beep-pattern stage in the digital clock.
- Watches the BCD time-of-day and the 1 Hz tick, then decides when that stage runs:
  - hourly chime: four low beeps at xx:59:56..59, one high beep at xx:00:00;
  - alarm: beeps for a fixed duration on a hh:mm match.
- Drives the pattern stage's active-low reset, its step pulse, and the tone select for the buzzer driver.

Parameters:
- ALARM_SECS, 30, alarm duration in seconds (1..255).
- HI_SECS, 1, duration of the high top-of-hour beep in seconds (1..15).
- CHIME_START, 8'h56, BCD second at which the low chime starts (minute is always 8'h59).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- tick_1hz  in  1  one-cycle pulse per second, same edge the time counters advance
- hh  in  8  current hour, BCD 00..23
- mm  in  8  current minute, BCD 00..59
- ss  in  8  current second, BCD 00..59
- set_mode  in  1  high while the user is setting time
- alarm_en  in  1  alarm armed
- alarm_hh  in  8  alarm hour, BCD
- alarm_mm  in  8  alarm minute, BCD
- alarm_stop  in  1  one-cycle pulse, user silences the alarm
- beep_rst_n  out  1  active-low reset to the pattern stage; low = stage held cleared
- beep_step  out  1  one-cycle pulse advancing the pattern stage
- tone_hi  out  1  0 = low tone, 1 = high tone
- chime_active  out  1  high in CHIME_LO or CHIME_HI
- alarm_active  out  1  high in ALARM

Behaviour:
- Reset (rst=0 at a clk edge) clears every output: beep_rst_n=0, beep_step=0, tone_hi=0, chime_active=0, alarm_active=0. It also clears state to IDLE, sec_cnt=0, beat_cnt=0 and alarm_pend=0.
- tick_q is tick_1hz registered one cycle. All time compares happen on tick_q cycles, when hh/mm/ss already show the new second.
- Outputs are registered; each updates on the edge after the tick_q cycle that caused it.
- A BCD field with a digit >9 never matches. No trigger fires in that case.
- States and transitions:
  - IDLE:
    - tick_q with mm=59 and ss=CHIME_START -> CHIME_LO, beat_cnt=1, beep_step pulse.
    - tick_q with mm=00 and ss=00 -> CHIME_HI, sec_cnt=0, beep_step pulse.
    - tick_q with alarm match (alarm_en, hh=alarm_hh, mm=alarm_mm, ss=00) and no chime match -> ALARM, sec_cnt=0, beep_step pulse.
  - CHIME_LO:
    - tone_hi=0, beep_rst_n=1.
    - Each tick_q gives a beep_step pulse and beat_cnt+1.
    - After the 4th beat, the next tick_q (xx:00:00) goes straight to CHIME_HI with a beep_step pulse.
    - With the default CHIME_START there are exactly 4 low beats.
  - CHIME_HI:
    - tone_hi=1, beep_rst_n=1.
    - On entry, beep_rst_n pulses low for one cycle to reload the pattern stage, with beep_step one cycle later.
    - After HI_SECS tick_q: go to ALARM if alarm_pend, else IDLE.
  - ALARM:
    - beep_rst_n=1; beep_step on every tick_q.
    - tone_hi toggles on every tick_q, starting at 1.
    - On the tick_q where sec_cnt reaches ALARM_SECS -> IDLE.
    - On alarm_stop -> IDLE on the next edge.
- Simultaneous events:
  - Chime and alarm match on the same tick_q (alarm at hh:00): chime wins and alarm_pend is set. ALARM starts when CHIME_HI ends, with full ALARM_SECS.
  - alarm_stop while alarm_pend: clears alarm_pend.
  - A chime trigger during ALARM is ignored; the alarm continues.
- set_mode=1 at any cycle:
  - Forces IDLE and clears alarm_pend.
  - beep_rst_n drops on the next edge.
  - Triggers are suppressed while set_mode is high.
- On return to IDLE, beep_rst_n=0 and tone_hi=0 on the same edge. No beep_step is issued in IDLE.
- rst=0 mid-sequence aborts immediately. The next chime waits for the next matching second; missed beats are never replayed.

Decomposition:
- Shared package clock_pkg:
  - state enum {IDLE, CHIME_LO, CHIME_HI, ALARM};
  - BCD constants BCD_59=8'h59, BCD_00=8'h00;
  - a bcd_valid helper function.
- One sub-module, chime_time_match: purely combinational. Produces chime_lo_hit, chime_hi_hit and alarm_hit from hh/mm/ss/alarm fields, including BCD validity.

Test Plan:
- Reset 3 cycles, then tick through 12:59:50 -> 13:00:02:
  - beep_step at ticks for 59:56, 57, 58, 59 with tone_hi=0;
  - then beep_step at 00:00 with tone_hi=1, preceded by a 1-cycle beep_rst_n low;
  - beep_rst_n=0 after 00:01.
- alarm_hh=07, alarm_mm=30, alarm_en=1, time 07:29:59 -> 07:30:00:
  - ALARM for 30 ticks, 30 beep_step pulses, tone_hi alternating 1,0,1...;
  - alarm_active drops at 07:30:30.
- Alarm at 08:00 (same tick as chime): low chime first, then CHIME_HI for HI_SECS, then ALARM starts at 08:00:01 and lasts 30 s.
- alarm_stop pulse 5 ticks into ALARM -> alarm_active=0 and beep_rst_n=0 on the next edge; no further beep_step.
- set_mode=1 during CHIME_LO at 59:57 -> IDLE next edge. With set_mode held through 00:00, no CHIME_HI occurs.
- ss=8'h5A (invalid BCD) with mm=59 -> no trigger. rst=0 during ALARM -> all outputs 0 next edge.
